// File: rtl/dir_input_conditioner.sv
// dir_input_conditioner
//   Button front end for the game model: tick generator, per-channel
//   two-flop synchronisers and tick-sampled debouncers, rising-edge press
//   detection, and a small FIFO of queued direction commands drained by
//   the game model's step strobe.
//
//   Optional feature macro: DIR_REVERSE_LOCK_EN
//     defined   - a popped command that is the 180-degree reverse of the
//                 current direction is consumed and ignored
//     undefined - reverse commands are applied like any other change
//
// Ports
//   clk         in   system clock
//   reset       in   synchronous, active-high
//   btn_raw     in   [NUM_BTN] asynchronous button levels (ch0..3 = L,R,U,D)
//   step        in   one-cycle strobe: apply next queued direction
//   tick        out  one-cycle pulse every CLK_HZ/TICK_HZ cycles
//   btn_clean   out  [NUM_BTN] debounced levels
//   btn_press   out  [NUM_BTN] one-cycle pulse per rising edge of btn_clean
//   dir         out  [2] current direction: 00 R, 01 L, 10 U, 11 D
//   dir_change  out  one-cycle pulse in the first cycle dir shows a new value
//   q_count     out  queued command count
//   overflow    out  one-cycle pulse when a press was dropped on a full FIFO
module dir_input_conditioner #(
    parameter int CLK_HZ       = 100000000,
    parameter int TICK_HZ      = 1000,
    parameter int NUM_BTN      = 4,
    parameter int STABLE_TICKS = 20,
    parameter int QUEUE_DEPTH  = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_BTN-1:0]            btn_raw,
    input  logic                          step,
    output logic                          tick,
    output logic [NUM_BTN-1:0]            btn_clean,
    output logic [NUM_BTN-1:0]            btn_press,
    output logic [1:0]                    dir,
    output logic                          dir_change,
    output logic [$clog2(QUEUE_DEPTH):0]  q_count,
    output logic                          overflow
);
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int TW  = $clog2(DIV);
    localparam int PW  = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int CW  = $clog2(QUEUE_DEPTH) + 1;

    // ---------------- tick generator ----------------
    logic [TW-1:0] tick_cnt;

    always_ff @(posedge clk) begin
        if (reset)
            tick_cnt <= '0;
        else if (tick_cnt == TW'(DIV - 1))
            tick_cnt <= '0;
        else
            tick_cnt <= tick_cnt + 1'b1;
    end

    // Decoded from the counter register only, so no input reaches it.
    assign tick = (tick_cnt == TW'(DIV - 1));

    // ---------------- synchronise, debounce, edge detect ----------------
    logic [NUM_BTN-1:0]      sync1, sync2, clean_d;
    logic [NUM_BTN-1:0][7:0] stab_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1     <= '0;
            sync2     <= '0;
            stab_cnt  <= '0;
            btn_clean <= '0;
            clean_d   <= '0;
            btn_press <= '0;
        end else begin
            sync1     <= btn_raw;
            sync2     <= sync1;
            clean_d   <= btn_clean;
            btn_press <= btn_clean & ~clean_d;
            if (tick) begin
                for (int i = 0; i < NUM_BTN; i++) begin
                    if (sync2[i] == btn_clean[i]) begin
                        stab_cnt[i] <= '0;
                    end else if (stab_cnt[i] == 8'(STABLE_TICKS - 1)) begin
                        // this tick is the STABLE_TICKS-th disagreeing sample
                        stab_cnt[i]  <= '0;
                        btn_clean[i] <= ~btn_clean[i];
                    end else begin
                        stab_cnt[i] <= stab_cnt[i] + 8'd1;
                    end
                end
            end
        end
    end

    // ---------------- direction command FIFO ----------------
    logic [1:0]    fifo [QUEUE_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [1:0]    push_cmd, head;
    logic          push_req, full, pop, push, take;

    // Lowest channel wins when several presses land in one cycle.
    always_comb begin
        push_cmd = 2'b11;
        if (btn_press[0])      push_cmd = 2'b01;
        else if (btn_press[1]) push_cmd = 2'b00;
        else if (btn_press[2]) push_cmd = 2'b10;
    end

    assign push_req = |btn_press[3:0];
    assign full     = (q_count == CW'(QUEUE_DEPTH));
    assign pop      = step && (q_count != '0);
    // a pop in the same cycle frees the slot the push needs
    assign push     = push_req && (!full || pop);
    assign head     = fifo[rd_ptr];

`ifdef DIR_REVERSE_LOCK_EN
    logic is_reverse;
    assign is_reverse = (head[1] == dir[1]) && (head[0] != dir[0]);
    assign take       = (head != dir) && !is_reverse;
`else
    assign take       = (head != dir);
`endif

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(QUEUE_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Storage needs no reset: pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (!reset && push)
            fifo[wr_ptr] <= push_cmd;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            q_count    <= '0;
            dir        <= 2'b00;
            dir_change <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            dir_change <= 1'b0;
            // Registered so no input reaches it combinationally; it shows
            // in the cycle the dropped push would have landed.
            overflow   <= push_req && full && !pop;
            if (push)
                wr_ptr <= ptr_next(wr_ptr);
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
                if (take) begin
                    dir        <= head;
                    dir_change <= 1'b1;
                end
            end
            if (push && !pop)
                q_count <= q_count + 1'b1;
            else if (pop && !push)
                q_count <= q_count - 1'b1;
        end
    end

endmodule
